// File: rtl/minesweeper_pkg.sv
// Shared types and constants for the minesweeper cell revealer:
// FSM states, special cell values and the neighbour walk order.
package minesweeper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        CHECK,
        POP,
        SCAN,
        LOST,
        WON
    } rev_state_e;

    localparam logic [3:0] CELL_MINE  = 4'd9;
    localparam logic [3:0] CELL_EMPTY = 4'd0;

    // Neighbour order: row above left-to-right, same row, row below.
    localparam int NB_COUNT = 8;
    localparam int NB_DX [NB_COUNT] = '{-1,  0,  1, -1, 1, -1, 0, 1};
    localparam int NB_DY [NB_COUNT] = '{-1, -1, -1,  0, 0,  1, 1, 1};

endpackage

// File: rtl/cell_revealer_if.sv
// Player command handshake between the game front end and the revealer.
interface cell_revealer_if #(
    parameter int CX_W = 5,
    parameter int CY_W = 4
);
    logic            cmd_valid;
    logic            cmd_flag;
    logic [CX_W-1:0] cmd_x;
    logic [CY_W-1:0] cmd_y;
    logic            cmd_ready;
    logic            cmd_done;

    modport master (
        output cmd_valid, cmd_flag, cmd_x, cmd_y,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_flag, cmd_x, cmd_y,
        output cmd_ready, cmd_done
    );
endinterface

// File: rtl/coord_stack.sv
// LIFO of packed {x,y} coordinates with a combinational top-of-stack read,
// so a pop is consumed in the same cycle it is requested.
module coord_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             full;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign full    = (ptr_q == PTR_W'(DEPTH));
    assign empty_o = (ptr_q == '0);
    assign wr_idx  = AW'(ptr_q);
    assign rd_idx  = AW'(ptr_q - 1'b1);
    assign top_o   = empty_o ? '0 : mem_q[rd_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (push_i && !full) begin
            ptr_d = ptr_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage carries no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i && !full) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/cell_revealer.sv
// Minesweeper reveal engine: applies player reveal/flag commands to the field
// and flood-fills zero regions with an explicit coordinate stack.
module cell_revealer
    import minesweeper_pkg::*;
#(
    parameter int  MAX_CELL_WIDTH  = 30,
    parameter int  MAX_CELL_HEIGHT = 16,
    localparam int W          = MAX_CELL_WIDTH,
    localparam int H          = MAX_CELL_HEIGHT,
    localparam int CELL_COUNT = W * H,
    localparam int CX_W       = $clog2(W),
    localparam int CY_W       = $clog2(H),
    localparam int CNT_W      = $clog2(CELL_COUNT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W-1:0][H-1:0][3:0]    game_field_i,
    input  logic [CX_W-1:0]             field_width_i,
    input  logic [CY_W-1:0]             field_height_i,
    input  logic [CNT_W-1:0]            mines_count_i,
    input  logic                        new_game_i,
    cell_revealer_if.slave              cmd,
    output logic [W-1:0][H-1:0]         revealed_o,
    output logic [W-1:0][H-1:0]         flagged_o,
    output logic                        lost_o,
    output logic                        won_o,
    output logic [CNT_W-1:0]            safe_left_o
);
    rev_state_e           state_q, state_d;
    logic [CX_W-1:0]      width_q, width_d, cur_x_q, cur_x_d;
    logic [CY_W-1:0]      height_q, height_d, cur_y_q, cur_y_d;
    logic                 flag_cmd_q, flag_cmd_d;
    logic [2:0]           nb_idx_q, nb_idx_d;
    logic [CNT_W-1:0]     safe_left_q, safe_left_d;
    logic [W-1:0][H-1:0]  revealed_q, revealed_d;
    logic [W-1:0][H-1:0]  flagged_q, flagged_d;

    logic                 cmd_ready, cmd_done;
    logic                 stk_push, stk_pop, stk_empty;
    logic [CX_W+CY_W-1:0] stk_push_data, stk_top;

    logic [CNT_W-1:0]     init_safe;
    logic                 tgt_ok, tgt_rev, tgt_flg, chk_open, chk_flood;
    logic [3:0]           tgt_val, nb_val;
    logic [CX_W:0]        nb_x;
    logic [CY_W:0]        nb_y;
    logic                 nb_open;

    // Playable cells exclude row/column 0 and anything past the latched size
    // or the physical array; the extra MSB keeps x-1 at x=0 out of range.
    function automatic logic in_field(input logic [CX_W:0] x, input logic [CY_W:0] y,
                                      input logic [CX_W-1:0] w, input logic [CY_W-1:0] h);
        return (x != '0) && (x < {1'b0, w}) && (x < (CX_W+1)'(W)) &&
               (y != '0) && (y < {1'b0, h}) && (y < (CY_W+1)'(H));
    endfunction

    assign init_safe = CNT_W'((32'(field_width_i) - 32'd1) * (32'(field_height_i) - 32'd1))
                       - mines_count_i;

    always_comb begin
        tgt_ok    = in_field({1'b0, cur_x_q}, {1'b0, cur_y_q}, width_q, height_q);
        tgt_val   = game_field_i[cur_x_q][cur_y_q];
        tgt_rev   = revealed_q[cur_x_q][cur_y_q];
        tgt_flg   = flagged_q[cur_x_q][cur_y_q];
        chk_open  = !flag_cmd_q && tgt_ok && !tgt_rev && !tgt_flg;
        chk_flood = chk_open && (tgt_val == CELL_EMPTY);
        nb_x      = {1'b0, cur_x_q} + (CX_W+1)'(NB_DX[nb_idx_q]);
        nb_y      = {1'b0, cur_y_q} + (CY_W+1)'(NB_DY[nb_idx_q]);
        nb_val    = game_field_i[nb_x[CX_W-1:0]][nb_y[CY_W-1:0]];
        nb_open   = in_field(nb_x, nb_y, width_q, height_q) &&
                    !revealed_q[nb_x[CX_W-1:0]][nb_y[CY_W-1:0]] &&
                    !flagged_q[nb_x[CX_W-1:0]][nb_y[CY_W-1:0]];
    end

    coord_stack #(
        .DEPTH (CELL_COUNT),
        .WIDTH (CX_W + CY_W)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (new_game_i),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (stk_push_data),
        .top_o       (stk_top),
        .empty_o     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            flag_cmd_q  <= 1'b0;
            nb_idx_q    <= '0;
            safe_left_q <= '0;
            revealed_q  <= '0;
            flagged_q   <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            flag_cmd_q  <= flag_cmd_d;
            nb_idx_q    <= nb_idx_d;
            safe_left_q <= safe_left_d;
            revealed_q  <= revealed_d;
            flagged_q   <= flagged_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        flag_cmd_d  = flag_cmd_q;
        nb_idx_d    = nb_idx_q;
        safe_left_d = safe_left_q;
        revealed_d  = revealed_q;
        flagged_d   = flagged_q;
        if (new_game_i) begin
            width_d     = field_width_i;
            height_d    = field_height_i;
            safe_left_d = init_safe;
            revealed_d  = '0;
            flagged_d   = '0;
            state_d     = READY;
        end else begin
            case (state_q)
                READY: begin
                    if (cmd.cmd_valid) begin
                        cur_x_d    = cmd.cmd_x;
                        cur_y_d    = cmd.cmd_y;
                        flag_cmd_d = cmd.cmd_flag;
                        state_d    = CHECK;
                    end
                end
                CHECK: begin
                    state_d = READY;
                    if (flag_cmd_q) begin
                        if (tgt_ok && !tgt_rev) begin
                            flagged_d[cur_x_q][cur_y_q] = !tgt_flg;
                        end
                    end else if (chk_open) begin
                        revealed_d[cur_x_q][cur_y_q] = 1'b1;
                        if (tgt_val == CELL_MINE) begin
                            state_d = LOST;
                        end else begin
                            safe_left_d = safe_left_q - 1'b1;
                            if (tgt_val == CELL_EMPTY) begin
                                state_d = POP;
                            end else if (safe_left_d == '0) begin
                                state_d = WON;
                            end
                        end
                    end
                end
                POP: begin
                    if (stk_empty) begin
                        state_d = (safe_left_q == '0) ? WON : READY;
                    end else begin
                        cur_x_d  = stk_top[CX_W+CY_W-1:CY_W];
                        cur_y_d  = stk_top[CY_W-1:0];
                        nb_idx_d = '0;
                        state_d  = SCAN;
                    end
                end
                SCAN: begin
                    if (nb_open) begin
                        revealed_d[nb_x[CX_W-1:0]][nb_y[CY_W-1:0]] = 1'b1;
                        safe_left_d = safe_left_q - 1'b1;
                    end
                    nb_idx_d = nb_idx_q + 1'b1;
                    if (nb_idx_q == 3'd7) begin
                        state_d = POP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are masked by reset and new_game so an aborted flood never reports done.
    always_comb begin
        cmd_ready     = rst && (state_q == READY);
        cmd_done      = rst && !new_game_i &&
                        (((state_q == CHECK) && !chk_flood) || ((state_q == POP) && stk_empty));
        stk_push      = rst && !new_game_i &&
                        (((state_q == CHECK) && chk_flood) ||
                         ((state_q == SCAN) && nb_open && (nb_val == CELL_EMPTY)));
        stk_pop       = rst && !new_game_i && (state_q == POP) && !stk_empty;
        stk_push_data = (state_q == SCAN) ? {nb_x[CX_W-1:0], nb_y[CY_W-1:0]}
                                          : {cur_x_q, cur_y_q};
        lost_o        = (state_q == LOST);
        won_o         = (state_q == WON);
    end

    assign cmd.cmd_ready = cmd_ready;
    assign cmd.cmd_done  = cmd_done;
    assign revealed_o    = revealed_q;
    assign flagged_o     = flagged_q;
    assign safe_left_o   = safe_left_q;

endmodule

// File: tb/tb_cell_revealer.sv
// Directed bench for cell_revealer on a 10x6 array: number/mine reveals,
// flood fill with win, flag interaction and reset/new-game priority.
module tb_cell_revealer;
    logic                    clk = 1'b0;
    logic                    rst;
    logic [9:0][5:0][3:0]    game_field;
    logic [3:0]              fw;
    logic [2:0]              fh;
    logic [5:0]              mines;
    logic                    new_game;
    logic [9:0][5:0]         revealed, flagged;
    logic                    lost, won;
    logic [5:0]              safe_left;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int lat;
    int d0;

    cell_revealer_if #(.CX_W(4), .CY_W(3)) cmd_if ();

    cell_revealer #(
        .MAX_CELL_WIDTH  (10),
        .MAX_CELL_HEIGHT (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .game_field_i   (game_field),
        .field_width_i  (fw),
        .field_height_i (fh),
        .mines_count_i  (mines),
        .new_game_i     (new_game),
        .cmd            (cmd_if),
        .revealed_o     (revealed),
        .flagged_o      (flagged),
        .lost_o         (lost),
        .won_o          (won),
        .safe_left_o    (safe_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_if.cmd_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] rect(input int x0, input int x1, input int y0, input int y1);
        logic [9:0][5:0] m;
        m = '0;
        for (int x = x0; x <= x1; x++)
            for (int y = y0; y <= y1; y++)
                m[x][y] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input int w, input int h, input int m);
        fw       = 4'(w);
        fh       = 3'(h);
        mines    = 6'(m);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        $display("new_game w=%0d h=%0d mines=%0d safe_left=%0d", w, h, m, safe_left);
    endtask

    // Issues one command; lat counts cycles from the accept edge to done (-1 on timeout).
    task automatic do_cmd(input logic f, input int x, input int y, output int lat_o);
        int budget;
        budget = 0;
        while (!cmd_if.cmd_ready && budget < 50) begin
            tick();
            budget++;
        end
        cmd_if.cmd_flag  = f;
        cmd_if.cmd_x     = 4'(x);
        cmd_if.cmd_y     = 3'(y);
        cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        lat_o = 1;
        while (!cmd_if.cmd_done && lat_o < 400) begin
            tick();
            lat_o++;
        end
        if (!cmd_if.cmd_done) lat_o = -1;
        tick();
        $display("cmd flag=%0d x=%0d y=%0d latency=%0d safe_left=%0d lost=%0d won=%0d",
                 f, x, y, lat_o, safe_left, lost, won);
    endtask

    initial begin
        rst              = 1'b0;
        game_field       = '0;
        fw               = '0;
        fh               = '0;
        mines            = '0;
        new_game         = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_flag  = 1'b0;
        cmd_if.cmd_x     = '0;
        cmd_if.cmd_y     = '0;
        repeat (3) tick();

        chk("rst_ready", cmd_if.cmd_ready, 0);
        chk("rst_done", cmd_if.cmd_done, 0);
        chk("rst_lost", lost, 0);
        chk("rst_won", won, 0);
        chk("rst_safe", safe_left, 0);
        chk("rst_revealed", revealed, 0);
        chk("rst_flagged", flagged, 0);

        // IDLE ignores commands until a new game starts
        rst = 1'b1;
        d0  = done_cnt;
        cmd_if.cmd_x = 4'd2; cmd_if.cmd_y = 3'd2; cmd_if.cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("idle_ready", cmd_if.cmd_ready, 0);
        chk("idle_no_done", done_cnt - d0, 0);
        chk("idle_revealed", revealed, 0);

        // Field A: mine at (3,3), a 2 at (4,3)
        game_field = '0;
        game_field[3][3] = 4'd9;
        game_field[4][3] = 4'd2;
        start_game(10, 6, 1);
        chk("a_ready", cmd_if.cmd_ready, 1);
        chk("a_safe_init", safe_left, 44);
        do_cmd(1'b0, 4, 3, lat);
        chk("a_num_lat", lat, 1);
        chk("a_num_revealed", revealed, rect(4, 4, 3, 3));
        chk("a_num_safe", safe_left, 43);
        chk("a_num_ready", cmd_if.cmd_ready, 1);
        do_cmd(1'b0, 3, 3, lat);
        chk("a_mine_lat", lat, 1);
        chk("a_mine_lost", lost, 1);
        chk("a_mine_won", won, 0);
        chk("a_mine_revealed", revealed, rect(4, 4, 3, 3) | rect(3, 3, 3, 3));
        chk("a_mine_ready", cmd_if.cmd_ready, 0);
        d0 = done_cnt;
        cmd_if.cmd_flag = 1'b0; cmd_if.cmd_x = 4'd5; cmd_if.cmd_y = 3'd5; cmd_if.cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("a_lost_ignores", done_cnt - d0, 0);
        chk("a_lost_held", lost, 1);

        // Field C: all zero 5x5, flood reveals every playable cell
        game_field = '0;
        start_game(5, 5, 0);
        chk("c_safe_init", safe_left, 16);
        d0 = done_cnt;
        do_cmd(1'b0, 2, 2, lat);
        chk("c_flood_lat", lat, 146);
        chk("c_won", won, 1);
        chk("c_lost", lost, 0);
        chk("c_revealed", revealed, rect(1, 4, 1, 4));
        chk("c_safe", safe_left, 0);
        chk("c_ready", cmd_if.cmd_ready, 0);
        repeat (5) tick();
        chk("c_one_done", done_cnt - d0, 1);

        // Field B: single playable row of zeros; flag handling and flag-bounded flood
        start_game(10, 2, 0);
        chk("b_safe_init", safe_left, 9);
        do_cmd(1'b1, 1, 1, lat);
        chk("b_flag_lat", lat, 1);
        chk("b_flag_set", flagged, rect(1, 1, 1, 1));
        do_cmd(1'b0, 1, 1, lat);
        chk("b_rev_flagged_lat", lat, 1);
        chk("b_rev_flagged", revealed, 0);
        chk("b_rev_flagged_keep", flagged, rect(1, 1, 1, 1));
        do_cmd(1'b1, 1, 1, lat);
        chk("b_flag_clear", flagged, 0);
        do_cmd(1'b0, 0, 1, lat);
        chk("b_border_lat", lat, 1);
        chk("b_border_revealed", revealed, 0);
        do_cmd(1'b0, 1, 2, lat);
        chk("b_outside_revealed", revealed, 0);
        do_cmd(1'b1, 4, 1, lat);
        chk("b_flag4", flagged, rect(4, 4, 1, 1));
        d0 = done_cnt;
        do_cmd(1'b0, 2, 1, lat);
        chk("b_flood_lat", lat, 29);
        chk("b_flood_revealed", revealed, rect(1, 3, 1, 1));
        chk("b_flood_flag_kept", flagged, rect(4, 4, 1, 1));
        chk("b_flood_safe", safe_left, 6);
        chk("b_flood_won", won, 0);
        chk("b_flood_ready", cmd_if.cmd_ready, 1);
        chk("b_flood_one_done", done_cnt - d0, 1);

        // Reset mid-flood, then new_game together with a command
        game_field = '0;
        start_game(5, 5, 0);
        cmd_if.cmd_flag = 1'b0; cmd_if.cmd_x = 4'd2; cmd_if.cmd_y = 3'd2; cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        repeat (8) tick();
        d0  = done_cnt;
        rst = 1'b0;
        tick();
        $display("reset asserted mid-flood");
        chk("r_ready", cmd_if.cmd_ready, 0);
        chk("r_done", cmd_if.cmd_done, 0);
        chk("r_revealed", revealed, 0);
        chk("r_safe", safe_left, 0);
        chk("r_lost_won", {lost, won}, 0);
        rst = 1'b1;
        repeat (20) tick();
        chk("r_no_done", done_cnt - d0, 0);
        chk("r_idle_ready", cmd_if.cmd_ready, 0);
        fw = 4'd5; fh = 3'd5; mines = 6'd0;
        new_game = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        tick();
        new_game = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        $display("new_game with simultaneous command");
        chk("ng_ready", cmd_if.cmd_ready, 1);
        chk("ng_safe", safe_left, 16);
        repeat (5) tick();
        chk("ng_cmd_dropped", revealed, 0);
        chk("ng_no_done", done_cnt - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cell_revealer.md
CELL_REVEALER -- requirements
Module: cell_revealer

Interface
REQ-001 Parameter MAX_CELL_WIDTH, default 30, maximum field columns.
REQ-002 Parameter MAX_CELL_HEIGHT, default 16, maximum field rows.
REQ-003 Derived: CELL_COUNT = W*H; CX_W = $clog2(W); CY_W = $clog2(H); CNT_W = $clog2(CELL_COUNT+1).
REQ-004 clk  in  1  clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 game_field_i  in  4 x [W][H]  cell values from the mine filler: 0-8 neighbour count, 9 mine.
REQ-007 field_width_i / field_height_i  in  CX_W / CY_W  field size, sampled on new_game_i.
REQ-008 mines_count_i  in  CNT_W  mines placed, sampled on new_game_i.
REQ-009 new_game_i  in  1  pulse, asserted with the filler's fill-finished pulse.
REQ-010 cmd_valid_i  in  1  player command request.
REQ-011 cmd_flag_i  in  1  command type: 0 reveal, 1 flag toggle.
REQ-012 cmd_x_i / cmd_y_i  in  CX_W / CY_W  target cell.
REQ-013 cmd_ready_o  out  1  high only in READY.
REQ-014 cmd_done_o  out  1  one-cycle pulse when a command is fully processed, including the flood.
REQ-015 revealed_o / flagged_o  out  1 x [W][H]  per-cell display state.
REQ-016 lost_o / won_o  out  1  terminal status, held until new_game_i.
REQ-017 safe_left_o  out  CNT_W  unrevealed non-mine cells remaining.

Function
REQ-018 A playable cell satisfies 1 <= x < width and 1 <= y < height; all other coordinates are never revealed or flagged, and commands targeting them are ignored.
REQ-019 The FSM states are IDLE, READY, CHECK, POP, SCAN, LOST and WON.
REQ-020 new_game_i (any state except reset) clears revealed_o and flagged_o, latches the size inputs, loads safe_left = (width-1)*(height-1) - mines_count, empties the stack, and enters READY on the next cycle.
REQ-021 A command is accepted when cmd_valid_i && cmd_ready_o; the target is latched and the FSM goes to CHECK.
REQ-022 CHECK, flag: if the cell is playable and unrevealed, flagged is toggled; done pulses and the FSM returns to READY.
REQ-023 CHECK, reveal of a non-playable, revealed or flagged cell: no state change; done pulses; return to READY.
REQ-024 CHECK, reveal of a value-9 cell: the cell is revealed, lost_o is set, done pulses, and the FSM enters LOST.
REQ-025 CHECK, reveal of a value 1-8 cell: the cell is revealed, safe_left is decremented, done pulses, and the FSM returns to READY (or WON).
REQ-026 CHECK, reveal of a value-0 cell: the cell is revealed, safe_left is decremented, the coordinate is pushed, and the FSM goes to POP.
REQ-027 POP: if the stack is empty, done pulses and the FSM goes to READY (or WON); otherwise the top is popped and the FSM goes to SCAN with the neighbour index at 0.
REQ-028 SCAN: one neighbour per cycle, indices 0-7 in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
REQ-029 In SCAN, a neighbour that is playable, unrevealed and unflagged is revealed and safe_left is decremented; if its value is 0 it is also pushed.
REQ-030 After index 7 the FSM returns to POP.
REQ-031 A cell is marked revealed at push time, so it is pushed at most once; a stack depth of CELL_COUNT can never overflow.
REQ-032 Coordinate arithmetic uses CX_W+1 / CY_W+1 bits, so x-1 at x=0 is out of range and is not wrapped.
REQ-033 When safe_left reaches 0, won_o is set once the current command completes (at its done pulse); lost has priority if both apply.
REQ-034 LOST and WON ignore commands (cmd_ready_o=0) until new_game_i.
REQ-035 cmd_valid_i is ignored outside READY; cmd_valid_i and new_game_i in the same cycle gives new_game_i priority, and the command is dropped.
REQ-036 Latency: flag or number reveal, accept at cycle N and done at N+1; flood, done at N+2+9*P, where P is the number of pops.

Reset
REQ-037 While rst=0 the FSM is IDLE and cmd_ready_o, cmd_done_o, lost_o and won_o are 0.
REQ-038 While rst=0, revealed_o and flagged_o are all 0, safe_left_o is 0, and the stack is empty.
REQ-039 Reset mid-flood aborts the flood immediately with no done pulse.
REQ-040 In IDLE, commands are ignored until new_game_i.

Structure
REQ-041 Package minesweeper_pkg holds the revealer state enum, CELL_MINE=4'd9, CELL_EMPTY=4'd0, and the neighbour offset table.
REQ-042 One sub-module, coord_stack, provides a LIFO of {x,y} coordinates (depth, width parameters; push, pop, top, empty, sync active-low reset).
REQ-043 The coord_stack read is combinational on top, so a pop completes in one cycle.

Verification
REQ-044 10x6 field, single mine at (3,3); reveal (3,3) -> done at N+1, lost_o=1, revealed_o[3][3]=1, cmd_ready_o=0.
REQ-045 Same field, value 2 at (4,3); reveal (4,3) -> only that cell revealed, safe_left 44->43, done at N+1.
REQ-046 All-zero 5x5 field, mines_count=0; reveal (2,2) -> all 16 playable cells revealed, border row/column untouched, won_o=1, exactly one done pulse.
REQ-047 Flag (1,1) then reveal (1,1) -> flagged_o[1][1]=1, revealed unchanged, done each time; flag (1,1) again -> flag cleared.
REQ-048 Zero region bounded by a flagged zero cell -> flood does not cross the flag, and the flagged cell stays unrevealed.
REQ-049 rst=0 asserted during SCAN -> next cycle IDLE, all outputs 0; new_game_i and cmd_valid_i together -> game restarts, command dropped.
